// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped BTB with 2-bit saturating direction counters, plus the EX-stage
//   resolution check that drives the hazard unit's branch_mispredict input.
//
// Ports
//   clk, rst_n                 : clock (rising edge), synchronous active-low reset
//   if_pc                      : fetch PC to predict
//   pred_taken, pred_target    : combinational prediction for if_pc
//   stall                      : pipeline stall; EX instruction will repeat, so no check
//   ex_valid                   : EX slot holds a real instruction
//   ex_is_branch               : EX instruction is a branch/jump
//   ex_pc, ex_taken, ex_target : resolved branch information
//   ex_pred_taken/_target      : prediction that travelled down from IF
//   branch_mispredict          : flush request (combinational)
//   redirect_pc                : correct next PC, meaningful when mispredicting
//   branch_cnt, mispredict_cnt : saturating statistics counters

module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic            branch_mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [PC_W-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [15:0]       r_branch_cnt;
    logic [15:0]       r_mispredict_cnt;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_if_hit;
    logic              w_ex_hit;
    logic              w_chk;
    logic              w_br_wrong;
    logic              w_alias;
    logic              w_mispredict;
    logic              w_unused;

    // PCs are word aligned; the low two bits never take part in lookup.
    assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];

    // Lookup: reads pre-update contents, no bypass from a same-cycle write.
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = rst_n && w_if_hit && r_ctr[w_if_idx][1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + PC_W'(4));

    // Resolution
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_chk      = rst_n && ex_valid && !stall;
    assign w_br_wrong = ex_is_branch &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
    // A non-branch predicted taken means its BTB slot belongs to another PC.
    assign w_alias    = !ex_is_branch && ex_pred_taken;
    assign w_mispredict = w_chk && (w_br_wrong || w_alias);

    assign branch_mispredict = w_mispredict;
    assign redirect_pc       = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + PC_W'(4));
    assign branch_cnt        = r_branch_cnt;
    assign mispredict_cnt    = r_mispredict_cnt;

    // Table training and statistics. tag/target are not reset; valid gates them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid          <= '{default: 1'b0};
            r_ctr            <= '{default: 2'b00};
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_chk) begin
            if (ex_is_branch) begin
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + 16'd1;
                end
                if (w_ex_hit) begin
                    if (ex_taken) begin
                        if (r_ctr[w_ex_idx] != 2'b11) begin
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
                        end
                        r_target[w_ex_idx] <= ex_target;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
                    end
                end else if (ex_taken) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= ex_target;
                    r_ctr[w_ex_idx]    <= 2'b10;
                end
            end else if (w_alias) begin
                r_valid[w_ex_idx] <= 1'b0;
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        branch_mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int          m_bcnt = 0;
    int          m_mcnt = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .stall(stall), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .branch_mispredict(branch_mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    function automatic int unsigned slot(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic logic exp_lookup_taken(input logic [31:0] pc);
        int unsigned s = slot(pc);
        if (!rst_n) return 1'b0;
        return m_valid[s] && (m_tag[s] == (pc >> 6)) && (m_ctr[s] >= 2);
    endfunction

    function automatic logic [31:0] exp_lookup_target(input logic [31:0] pc);
        if (exp_lookup_taken(pc)) return m_target[slot(pc)];
        return pc + 32'd4;
    endfunction

    function automatic logic exp_mis();
        if (!rst_n || !ex_valid || stall) return 1'b0;
        if (ex_is_branch)
            return (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
        return ex_pred_taken;
    endfunction

    function automatic logic [31:0] exp_redirect();
        if (ex_is_branch && ex_taken) return ex_target;
        return ex_pc + 32'd4;
    endfunction

    function automatic void model_commit();
        int unsigned s = slot(ex_pc);
        bit hit = m_valid[s] && (m_tag[s] == (ex_pc >> 6));
        bit mis = exp_mis();
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 0;
            end
            m_bcnt = 0;
            m_mcnt = 0;
            return;
        end
        if (!ex_valid || stall) return;
        if (ex_is_branch) begin
            if (m_bcnt < 65535) m_bcnt++;
            if (hit && ex_taken) begin
                m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_target[s] = ex_target;
            end else if (hit) begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end else if (ex_taken) begin
                m_valid[s]  = 1;
                m_tag[s]    = ex_pc >> 6;
                m_target[s] = ex_target;
                m_ctr[s]    = 2;
            end
        end else if (ex_pred_taken) begin
            m_valid[s] = 0;
        end
        if (mis && m_mcnt < 65535) m_mcnt++;
    endfunction

    task automatic set_ex(input logic v, input logic br, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        stall = 1'b0;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; if_pc = 32'h100;
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL rst_pred_taken got %b exp 0", pred_taken); end
        tests_run++; if (pred_target !== 32'h104) begin tests_failed++; $display("FAIL rst_pred_target got %h exp 00000104", pred_target); end
        tests_run++; if (branch_mispredict !== 1'b0) begin tests_failed++; $display("FAIL rst_mispredict got %b exp 0", branch_mispredict); end
        tick(); tick();
        rst_n = 1'b1; idle(); #1;
        tests_run++; if (branch_cnt !== 16'h0) begin tests_failed++; $display("FAIL rst_branch_cnt got %h exp 0000", branch_cnt); end
        tests_run++; if (mispredict_cnt !== 16'h0) begin tests_failed++; $display("FAIL rst_mispredict_cnt got %h exp 0000", mispredict_cnt); end
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL rst_cold_lookup got %b exp 0", pred_taken); end
    endtask

    task automatic test_cold();
        if_pc = 32'h100;
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        tests_run++; if (pred_target !== 32'h104) begin tests_failed++; $display("FAIL cold_pred_target got %h exp 00000104", pred_target); end
        tests_run++; if (branch_mispredict !== 1'b1) begin tests_failed++; $display("FAIL cold_mispredict got %b exp 1", branch_mispredict); end
        tests_run++; if (redirect_pc !== 32'h200) begin tests_failed++; $display("FAIL cold_redirect got %h exp 00000200", redirect_pc); end
        tick(); idle(); #1;
        tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL cold_trained_taken got %b exp 1", pred_taken); end
        tests_run++; if (pred_target !== 32'h200) begin tests_failed++; $display("FAIL cold_trained_target got %h exp 00000200", pred_target); end
        tests_run++; if (branch_cnt !== 16'd1 || mispredict_cnt !== 16'd1) begin tests_failed++; $display("FAIL cold_counters got %0d/%0d exp 1/1", branch_cnt, mispredict_cnt); end
    endtask

    task automatic test_hysteresis();
        logic [3:0] taken_seq = 4'b0011;   // bit k = outcome k
        logic [3:0] mis_seq   = 4'b1100;
        logic [3:0] pred_seq  = 4'b0111;   // prediction after outcome k
        if_pc = 32'h100;
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b1, 1'b1, 32'h100, taken_seq[k], 32'h200,
                   exp_lookup_taken(32'h100), exp_lookup_target(32'h100));
            #1;
            tests_run++; if (branch_mispredict !== mis_seq[k]) begin tests_failed++; $display("FAIL hyst_mispredict[%0d] got %b exp %b", k, branch_mispredict, mis_seq[k]); end
            if (!taken_seq[k]) begin
                tests_run++; if (redirect_pc !== 32'h104) begin tests_failed++; $display("FAIL hyst_redirect[%0d] got %h exp 00000104", k, redirect_pc); end
            end
            tick(); idle(); #1;
            tests_run++; if (pred_taken !== pred_seq[k]) begin tests_failed++; $display("FAIL hyst_pred[%0d] got %b exp %b", k, pred_taken, pred_seq[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_target_change();
        if_pc = 32'h100;
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, exp_lookup_taken(32'h100), exp_lookup_target(32'h100));
        tick(); idle(); #1;
        tests_run++; if (pred_target !== 32'h200) begin tests_failed++; $display("FAIL tgt_before got %h exp 00000200", pred_target); end
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        #1;
        tests_run++; if (branch_mispredict !== 1'b1) begin tests_failed++; $display("FAIL tgt_mispredict got %b exp 1", branch_mispredict); end
        tests_run++; if (redirect_pc !== 32'h300) begin tests_failed++; $display("FAIL tgt_redirect got %h exp 00000300", redirect_pc); end
        tick(); idle(); #1;
        tests_run++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin tests_failed++; $display("FAIL tgt_after got %b/%h exp 1/00000300", pred_taken, pred_target); end
    endtask

    task automatic test_alias();
        int mc = m_mcnt;
        int bc = m_bcnt;
        if_pc = 32'h100;
        set_ex(1'b1, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h300);
        #1;
        tests_run++; if (branch_mispredict !== 1'b1) begin tests_failed++; $display("FAIL alias_mispredict got %b exp 1", branch_mispredict); end
        tests_run++; if (redirect_pc !== 32'h144) begin tests_failed++; $display("FAIL alias_redirect got %h exp 00000144", redirect_pc); end
        tick(); idle(); #1;
        tests_run++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin tests_failed++; $display("FAIL alias_invalidated got %b/%h exp 0/00000104", pred_taken, pred_target); end
        tests_run++; if (mispredict_cnt !== 16'(mc + 1) || branch_cnt !== 16'(bc)) begin tests_failed++; $display("FAIL alias_counters got %0d/%0d exp %0d/%0d", branch_cnt, mispredict_cnt, bc, mc + 1); end
    endtask

    task automatic test_stall_bubble();
        int bc = m_bcnt;
        int mc = m_mcnt;
        set_ex(1'b1, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (branch_mispredict !== 1'b0) begin tests_failed++; $display("FAIL stall_mispredict[%0d] got %b exp 0", k, branch_mispredict); end
            tests_run++; if (branch_cnt !== 16'(bc) || mispredict_cnt !== 16'(mc)) begin tests_failed++; $display("FAIL stall_counters[%0d] got %0d/%0d exp %0d/%0d", k, branch_cnt, mispredict_cnt, bc, mc); end
            tick();
        end
        stall = 1'b0; #1;
        tests_run++; if (branch_mispredict !== 1'b1 || redirect_pc !== 32'h400) begin tests_failed++; $display("FAIL stall_release got %b/%h exp 1/00000400", branch_mispredict, redirect_pc); end
        tick();
        set_ex(1'b0, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h184); #1;
        tests_run++; if (branch_mispredict !== 1'b0) begin tests_failed++; $display("FAIL bubble_mispredict got %b exp 0", branch_mispredict); end
        tests_run++; if (branch_cnt !== 16'(bc + 1) || mispredict_cnt !== 16'(mc + 1)) begin tests_failed++; $display("FAIL stall_single_pulse got %0d/%0d exp %0d/%0d", branch_cnt, mispredict_cnt, bc + 1, mc + 1); end
        tick(); #1;
        tests_run++; if (branch_cnt !== 16'(bc + 1) || mispredict_cnt !== 16'(mc + 1)) begin tests_failed++; $display("FAIL bubble_counters got %0d/%0d exp %0d/%0d", branch_cnt, mispredict_cnt, bc + 1, mc + 1); end
        idle();
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 6))
            0: return 32'h100;
            1: return 32'h140;
            2: return 32'h180;
            3: return 32'h1c0;
            4: return 32'h104;
            5: return 32'h108;
            default: return 32'h2100;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        e_pt;
        logic [31:0] e_ptg;
        for (int k = 0; k < 400; k++) begin
            pc  = pick_pc();
            tgt = ($urandom_range(0, 1) == 0) ? 32'h200 : ($urandom() & 32'hFFFF_FFFC);
            if ($urandom_range(0, 3) != 0)
                set_ex($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, pc,
                       1'($urandom_range(0, 1)), tgt, exp_lookup_taken(pc), exp_lookup_target(pc));
            else
                set_ex($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, pc,
                       1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)), pick_pc());
            stall = ($urandom_range(0, 5) == 0);
            if_pc = pick_pc();
            #1;
            e_pt  = exp_lookup_taken(if_pc);
            e_ptg = exp_lookup_target(if_pc);
            tests_run++; if (pred_taken !== e_pt) begin tests_failed++; $display("FAIL rnd_pred_taken[%0d] got %b exp %b", k, pred_taken, e_pt); end
            tests_run++; if (pred_target !== e_ptg) begin tests_failed++; $display("FAIL rnd_pred_target[%0d] got %h exp %h", k, pred_target, e_ptg); end
            tests_run++; if (branch_mispredict !== exp_mis()) begin tests_failed++; $display("FAIL rnd_mispredict[%0d] got %b exp %b", k, branch_mispredict, exp_mis()); end
            tests_run++; if (redirect_pc !== exp_redirect()) begin tests_failed++; $display("FAIL rnd_redirect[%0d] got %h exp %h", k, redirect_pc, exp_redirect()); end
            tests_run++; if (branch_cnt !== 16'(m_bcnt) || mispredict_cnt !== 16'(m_mcnt)) begin tests_failed++; $display("FAIL rnd_counters[%0d] got %0d/%0d exp %0d/%0d", k, branch_cnt, mispredict_cnt, m_bcnt, m_mcnt); end
            tick();
        end
        idle();
    endtask

    task automatic test_saturation();
        set_ex(1'b1, 1'b1, 32'h3000, 1'b0, 32'h3100, 1'b0, 32'h3004);
        stall = 1'b0;
        repeat (65540) tick();
        #1;
        tests_run++; if (branch_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_branch_cnt got %h exp ffff", branch_cnt); end
        tests_run++; if (mispredict_cnt !== 16'(m_mcnt)) begin tests_failed++; $display("FAIL sat_mispredict_cnt got %0d exp %0d", mispredict_cnt, m_mcnt); end
        idle();
    endtask

    task automatic test_reset_midstream();
        if_pc = 32'h100;
        repeat (2) begin
            set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, exp_lookup_taken(32'h100), exp_lookup_target(32'h100));
            tick();
        end
        idle(); #1;
        tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL mid_trained got %b exp 1", pred_taken); end
        rst_n = 1'b0;
        set_ex(1'b1, 1'b1, 32'h1c0, 1'b1, 32'h700, 1'b0, 32'h1c4); #1;
        tests_run++; if (branch_mispredict !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_mispredict got %b exp 0", branch_mispredict); end
        tests_run++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin tests_failed++; $display("FAIL mid_rst_lookup got %b/%h exp 0/00000104", pred_taken, pred_target); end
        tick();
        rst_n = 1'b1; idle(); #1;
        tests_run++; if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin tests_failed++; $display("FAIL mid_counters got %h/%h exp 0000/0000", branch_cnt, mispredict_cnt); end
        tests_run++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin tests_failed++; $display("FAIL mid_after_lookup got %b/%h exp 0/00000104", pred_taken, pred_target); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_pc = '0; idle();
        @(negedge clk);
        test_reset();
        test_cold();
        test_hysteresis();
        test_target_change();
        test_alias();
        test_stall_bubble();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
